// File: rtl/pixelpaint_pkg.sv
// pixelpaint_pkg
//   Shared definitions for the pixelpaint framebuffer stage: default
//   geometry, framebuffer depth/address width, the 2-bit colour palette
//   and the framebuffer controller state encoding.
package pixelpaint_pkg;

    localparam int CELL_SHIFT_DEF  = 3;    // 8x8-pixel cells
    localparam int H_CELLS_DEF     = 80;   // 640 >> 3
    localparam int V_CELLS_DEF     = 60;   // 480 >> 3
    localparam int SYNC_STAGES_DEF = 2;
    localparam int COORD_W         = 10;   // width of px/py from the vga driver

    localparam int CELLS  = H_CELLS_DEF * V_CELLS_DEF;
    localparam int ADDR_W = $clog2(CELLS);

    typedef enum logic [1:0] {
        CLEAR    = 2'd0,
        WAIT_SOF = 2'd1,
        RUN      = 2'd2
    } fb_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t PAL_CODE0 = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    localparam rgb_t PAL_CODE1 = '{r: 8'h00, g: 8'hFF, b: 8'h00};
    localparam rgb_t PAL_CODE2 = '{r: 8'h00, g: 8'h00, b: 8'hFF};
    localparam rgb_t PAL_CODE3 = '{r: 8'h00, g: 8'h00, b: 8'h3F};
    localparam rgb_t PAL_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

    function automatic rgb_t palette(input logic [1:0] code);
        rgb_t c;
        case (code)
            2'd0:    c = PAL_CODE0;
            2'd1:    c = PAL_CODE1;
            2'd2:    c = PAL_CODE2;
            default: c = PAL_CODE3;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pixelpaint_gpio_rx.sv
// pixelpaint_gpio_rx
//   Brings the asynchronous Raspberry Pi GPIO lines into the pixel clock
//   domain and detects rising edges on the write strobe and start-of-frame.
// Ports
//   clk, rst_n    pixel clock, async active-low reset (already release-synchronised)
//   gpio_data     2-bit colour code from the RPi (asynchronous)
//   gpio_strobe   RPi write strobe (asynchronous)
//   gpio_sof      RPi start-of-frame (asynchronous)
//   strobe_pulse  one-cycle pulse per synchronised strobe rising edge
//   sof_pulse     one-cycle pulse per synchronised sof rising edge
//   data          synchronised colour code, aligned with strobe_pulse
module pixelpaint_gpio_rx
    import pixelpaint_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] gpio_data,
    input  logic       gpio_strobe,
    input  logic       gpio_sof,
    output logic       strobe_pulse,
    output logic       sof_pulse,
    output logic [1:0] data
);

    localparam int NB = 4;

    logic [NB-1:0] async_in;
    logic [NB-1:0] sync_out;
    logic [1:0]    prev_q;
    logic [1:0]    prev_d;

    // Bit order: {sof, strobe, data[1:0]}. Data and strobe share the same
    // synchroniser depth so the data copy lines up with the strobe edge.
    assign async_in = {gpio_sof, gpio_strobe, gpio_data};

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_q;
            logic [SYNC_STAGES-1:0] chain_d;

            always_comb begin
                chain_d = {chain_q[SYNC_STAGES-2:0], async_in[gi]};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain_q <= '0;
                end else begin
                    chain_q <= chain_d;
                end
            end

            assign sync_out[gi] = chain_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        prev_d = sync_out[3:2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign strobe_pulse = sync_out[2] & ~prev_q[0];
    assign sof_pulse    = sync_out[3] & ~prev_q[1];
    assign data         = sync_out[1:0];

endmodule

// File: rtl/pixelpaint_fb.sv
// pixelpaint_fb
//   Coarse framebuffer between the Raspberry Pi GPIO link and the vga driver.
//   Cells written over GPIO are stored as 2-bit codes and looked up per pixel
//   with a fixed two-cycle latency, then mapped through a 4-entry palette.
// Ports
//   clk, rst_n            pixel clock; async-assert active-low reset
//   gpio_data/strobe/sof  asynchronous RPi write interface
//   px, py, de            pixel coordinate and display enable from the vga driver
//   r, g, b               registered pixel colour (two cycles after px/py/de)
//   frame_done            one-cycle pulse when the last cell is written
//   overrun               sticky: a write arrived after frame_done without a new sof
//   busy                  high while the post-reset clear sweep runs
module pixelpaint_fb
    import pixelpaint_pkg::*;
#(
    parameter int CELL_SHIFT  = CELL_SHIFT_DEF,
    parameter int H_CELLS     = H_CELLS_DEF,
    parameter int V_CELLS     = V_CELLS_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] gpio_data,
    input  logic       gpio_strobe,
    input  logic       gpio_sof,
    input  logic [9:0] px,
    input  logic [9:0] py,
    input  logic       de,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       frame_done,
    output logic       overrun,
    output logic       busy
);

    localparam int NUM_CELLS = H_CELLS * V_CELLS;
    localparam int MEM_AW    = $clog2(NUM_CELLS);
    localparam int CX_W      = COORD_W - CELL_SHIFT;

    localparam logic [MEM_AW-1:0] LAST_CELL = MEM_AW'(NUM_CELLS - 1);
    localparam logic [CX_W:0]     H_LIM     = (CX_W + 1)'(H_CELLS);
    localparam logic [CX_W:0]     V_LIM     = (CX_W + 1)'(V_CELLS);

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on a clock edge so that no
    // flop leaves reset in a different cycle from its neighbours.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_int_n;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // GPIO receive
    // ------------------------------------------------------------------
    logic       strobe_pulse;
    logic       sof_pulse;
    logic [1:0] rx_data;

    pixelpaint_gpio_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_gpio_rx (
        .clk         (clk),
        .rst_n       (rst_int_n),
        .gpio_data   (gpio_data),
        .gpio_strobe (gpio_strobe),
        .gpio_sof    (gpio_sof),
        .strobe_pulse(strobe_pulse),
        .sof_pulse   (sof_pulse),
        .data        (rx_data)
    );

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    fb_state_t state_q, state_d;

    logic [MEM_AW-1:0] caddr_q, caddr_d;
    logic [MEM_AW-1:0] waddr_q, waddr_d;
    logic              overrun_q, overrun_d;
    logic              complete_q, complete_d;   // frame finished, no sof since
    logic              frame_done_q, frame_done_d;

    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [1:0]        mem_wdata;
    logic              busy_c;

    // State register
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:    if (caddr_q == LAST_CELL) state_d = WAIT_SOF;
            WAIT_SOF: if (sof_pulse)            state_d = RUN;
            RUN:      state_d = RUN;
            default:  state_d = CLEAR;
        endcase
    end

    // Outputs and write-side datapath
    always_comb begin
        logic [MEM_AW-1:0] wr_base;
        logic              done_eff;
        logic              accept;

        caddr_d      = caddr_q;
        waddr_d      = waddr_q;
        overrun_d    = overrun_q;
        complete_d   = complete_q;
        frame_done_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = waddr_q;
        mem_wdata    = rx_data;
        busy_c       = 1'b0;
        wr_base      = waddr_q;
        done_eff     = complete_q;
        accept       = 1'b0;

        case (state_q)
            CLEAR: begin
                busy_c    = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = caddr_q;
                mem_wdata = 2'd0;
                caddr_d   = (caddr_q == LAST_CELL) ? '0 : caddr_q + MEM_AW'(1);
            end
            WAIT_SOF, RUN: begin
                // A sof edge is applied before a strobe edge in the same
                // cycle, so a coincident write lands in cell 0. In WAIT_SOF
                // that coincident sof is also what arms the write.
                accept = (state_q == RUN) || sof_pulse;
                if (sof_pulse) begin
                    wr_base    = '0;
                    done_eff   = 1'b0;
                    waddr_d    = '0;
                    overrun_d  = 1'b0;
                    complete_d = 1'b0;
                end
                if (strobe_pulse && accept) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_base;
                    if (done_eff) begin
                        overrun_d = 1'b1;
                    end
                    if (wr_base == LAST_CELL) begin
                        waddr_d      = '0;
                        frame_done_d = 1'b1;
                        complete_d   = 1'b1;
                    end else begin
                        waddr_d = wr_base + MEM_AW'(1);
                    end
                end
            end
            default: begin
                busy_c = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            caddr_q      <= '0;
            waddr_q      <= '0;
            overrun_q    <= 1'b0;
            complete_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            caddr_q      <= caddr_d;
            waddr_q      <= waddr_d;
            overrun_q    <= overrun_d;
            complete_q   <= complete_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Read path: c0 address, c1 registered RAM read, c2 palette register
    // ------------------------------------------------------------------
    logic [CX_W-1:0]   cell_x;
    logic [CX_W-1:0]   cell_y;
    logic              in_range;
    logic [MEM_AW-1:0] raddr_c0;
    logic              vis_q, vis_d;
    logic [1:0]        mem_rdata_q;
    rgb_t              rgb_q, rgb_d;
    logic              unused_subcell_bits;

    assign cell_x   = px[COORD_W-1:CELL_SHIFT];
    assign cell_y   = py[COORD_W-1:CELL_SHIFT];
    assign in_range = ({1'b0, cell_x} < H_LIM) && ({1'b0, cell_y} < V_LIM);

    // The position inside a cell never affects which code is shown.
    assign unused_subcell_bits = ^{px[CELL_SHIFT-1:0], py[CELL_SHIFT-1:0]};

    // cell_y * H_CELLS as a sum of shifted copies, one per set bit of the
    // constant (80 -> <<6 plus <<4), so no multiplier is needed.
    always_comb begin
        raddr_c0 = MEM_AW'(cell_x);
        for (int i = 0; i < 32; i++) begin
            if (H_CELLS[i]) begin
                raddr_c0 = raddr_c0 + (MEM_AW'(cell_y) << i);
            end
        end
    end

    always_comb begin
        vis_d = de & in_range;
    end

    // Framebuffer: one write port, one registered read port. A read of the
    // address being written in the same cycle returns the old contents.
    logic [1:0] mem [NUM_CELLS];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        mem_rdata_q <= mem[raddr_c0];
    end

    // Busy is checked at the palette stage so nothing stale leaks out while
    // the clear sweep is still overwriting the memory.
    always_comb begin
        rgb_d = PAL_BLACK;
        if (vis_q && !busy_c) begin
            rgb_d = palette(mem_rdata_q);
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            vis_q <= 1'b0;
            rgb_q <= PAL_BLACK;
        end else begin
            vis_q <= vis_d;
            rgb_q <= rgb_d;
        end
    end

    assign r          = rgb_q.r;
    assign g          = rgb_q.g;
    assign b          = rgb_q.b;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign busy       = busy_c;

endmodule

// File: tb/tb_pixelpaint_fb.sv
module tb_pixelpaint_fb;

    localparam int NC        = 4800;
    localparam int RST_SYNC  = 2;     // reset-release synchroniser depth

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] gpio_data = 2'd0;
    logic       gpio_strobe = 1'b0;
    logic       gpio_sof = 1'b0;
    logic [9:0] px = 10'd0;
    logic [9:0] py = 10'd0;
    logic       de = 1'b0;
    logic [7:0] r, g, b;
    logic       frame_done, overrun, busy;

    int n_vec = 0;
    int n_err = 0;
    int fd_count = 0;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        d;
        logic [23:0] rgb;
    } vec_t;

    vec_t tbl[14];

    pixelpaint_fb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gpio_data  (gpio_data),
        .gpio_strobe(gpio_strobe),
        .gpio_sof   (gpio_sof),
        .px         (px),
        .py         (py),
        .de         (de),
        .r          (r),
        .g          (g),
        .b          (b),
        .frame_done (frame_done),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic read_px(input string name, input logic [9:0] x, input logic [9:0] y,
                           input logic d, input logic [23:0] exp);
        @(negedge clk);
        px = x; py = y; de = d;
        repeat (2) @(negedge clk);
        check(name, 32'({r, g, b}), 32'(exp));
    endtask

    task automatic send_strobe(input logic [1:0] d, input int hi, input int lo);
        @(negedge clk);
        gpio_data = d;
        gpio_strobe = 1'b1;
        repeat (hi) @(negedge clk);
        gpio_strobe = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_sof();
        @(negedge clk);
        gpio_sof = 1'b1;
        repeat (4) @(negedge clk);
        gpio_sof = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_both(input logic [1:0] d);
        @(negedge clk);
        gpio_data = d;
        gpio_sof = 1'b1;
        gpio_strobe = 1'b1;
        repeat (4) @(negedge clk);
        gpio_sof = 1'b0;
        gpio_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Releases reset and counts clock edges until busy drops; a strobe with
    // data 3 is thrown in during the clear sweep and must be ignored.
    task automatic release_and_clear(output int cycles);
        @(negedge clk);
        rst_n = 1'b1;
        cycles = 0;
        while (busy === 1'b1 && cycles < NC + 50) begin
            @(negedge clk);
            cycles++;
            if (cycles == 100) begin
                gpio_data = 2'd3;
                gpio_strobe = 1'b1;
            end
            if (cycles == 104) gpio_strobe = 1'b0;
            if (cycles == 200) check("clear_rgb_black", 32'({r, g, b}), 32'h0);
            if (cycles == NC + RST_SYNC - 1) check("clear_busy_late", 32'(busy), 32'h1);
        end
    endtask

    initial begin
        int cyc;

        // ---------------- 1: reset and clear sweep ----------------
        px = 10'd0; py = 10'd0; de = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_rgb", 32'({r, g, b}), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        release_and_clear(cyc);
        // CLEAR lasts NC cycles once the internal reset has been released.
        check("clear_len", 32'(cyc), 32'(NC + RST_SYNC));
        check("clear_busy_low", 32'(busy), 32'h0);

        // ---------------- 5: strobes before the first sof ----------------
        send_strobe(2'd3, 4, 4);
        send_strobe(2'd2, 4, 4);
        read_px("pre_sof_cell0", 10'd0, 10'd0, 1'b1, 24'hFF0000);
        read_px("pre_sof_cell1", 10'd8, 10'd0, 1'b1, 24'hFF0000);

        // ---------------- 2: three writes then read-back ----------------
        send_sof();
        send_strobe(2'd1, 4, 4);
        send_strobe(2'd2, 4, 4);
        send_strobe(2'd3, 4, 4);

        // Latency: red cell held, then switch to cell 0 (green).
        @(negedge clk);
        px = 10'd24; py = 10'd0; de = 1'b1;
        repeat (3) @(negedge clk);
        px = 10'd0;
        @(negedge clk);
        check("latency_c1_old", 32'({r, g, b}), 32'hFF0000);
        @(negedge clk);
        check("latency_c2_new", 32'({r, g, b}), 32'h00FF00);

        tbl[0]  = '{10'd0,   10'd0,   1'b1, 24'h00FF00};
        tbl[1]  = '{10'd7,   10'd7,   1'b1, 24'h00FF00};
        tbl[2]  = '{10'd8,   10'd0,   1'b1, 24'h0000FF};
        tbl[3]  = '{10'd15,  10'd3,   1'b1, 24'h0000FF};
        tbl[4]  = '{10'd16,  10'd0,   1'b1, 24'h00003F};
        tbl[5]  = '{10'd23,  10'd7,   1'b1, 24'h00003F};
        tbl[6]  = '{10'd24,  10'd0,   1'b1, 24'hFF0000};
        tbl[7]  = '{10'd0,   10'd8,   1'b1, 24'hFF0000};
        tbl[8]  = '{10'd639, 10'd479, 1'b1, 24'hFF0000};
        tbl[9]  = '{10'd0,   10'd0,   1'b0, 24'h000000};
        tbl[10] = '{10'd700, 10'd0,   1'b1, 24'h000000};
        tbl[11] = '{10'd0,   10'd480, 1'b1, 24'h000000};
        tbl[12] = '{10'd640, 10'd479, 1'b1, 24'h000000};
        tbl[13] = '{10'd8,   10'd8,   1'b1, 24'hFF0000};
        for (int i = 0; i < 14; i++) begin
            read_px($sformatf("tbl%0d_x%0d_y%0d_de%0d", i, tbl[i].x, tbl[i].y, tbl[i].d),
                    tbl[i].x, tbl[i].y, tbl[i].d, tbl[i].rgb);
        end

        // ---------------- 3: full frame, frame_done, overrun ----------------
        send_sof();
        fd_count = 0;
        for (int i = 0; i < NC; i++) begin
            send_strobe(2'(i % 3), 2, 2);
            if (i == NC - 2) check("fd_before_last", 32'(fd_count), 32'h0);
        end
        check("fd_after_last", 32'(fd_count), 32'h1);
        check("overrun_at_done", 32'(overrun), 32'h0);
        send_strobe(2'd2, 4, 4);
        check("overrun_set", 32'(overrun), 32'h1);
        check("fd_single_pulse", 32'(fd_count), 32'h1);
        read_px("ovr_cell0_blue", 10'd0, 10'd0, 1'b1, 24'h0000FF);
        read_px("frame_cell1", 10'd8, 10'd0, 1'b1, 24'h00FF00);
        read_px("frame_cell81", 10'd8, 10'd8, 1'b1, 24'hFF0000);
        read_px("frame_cell2405", 10'd40, 10'd240, 1'b1, 24'h0000FF);
        read_px("frame_cell4799", 10'd632, 10'd472, 1'b1, 24'h0000FF);
        send_sof();
        check("overrun_cleared", 32'(overrun), 32'h0);

        // ---------------- 4: sof and strobe in the same cycle ----------------
        send_strobe(2'd3, 4, 4);
        send_strobe(2'd3, 4, 4);
        send_both(2'd2);
        send_strobe(2'd1, 4, 4);
        read_px("both_cell0_blue", 10'd0, 10'd0, 1'b1, 24'h0000FF);
        read_px("both_cell1_green", 10'd8, 10'd0, 1'b1, 24'h00FF00);
        read_px("both_cell2_kept", 10'd16, 10'd0, 1'b1, 24'h0000FF);

        // ---------------- 6: asynchronous reset mid-frame ----------------
        read_px("pre_reset_cell0", 10'd0, 10'd0, 1'b1, 24'h0000FF);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rgb", 32'({r, g, b}), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h1);
        repeat (2) @(negedge clk);
        release_and_clear(cyc);
        check("reclear_len", 32'(cyc), 32'(NC + RST_SYNC));
        read_px("reclear_cell0_red", 10'd0, 10'd0, 1'b1, 24'hFF0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
